// File: rtl/qr_pkg.sv
// Shared QR-engine definitions: Q8.8 format constants and the norm_scale FSM state type.
package qr_pkg;

    localparam int unsigned QW      = 16;
    localparam int unsigned QF      = 8;
    localparam logic [QW-1:0] Q_MAX = 16'h7FFF;
    localparam logic [QW-1:0] Q_MIN = 16'h8000;
    // Half an LSB of the fractional part, added before the >>> QF for round-half-up.
    localparam int unsigned Q_ROUND = 32'd1 << (QF - 1);

    typedef enum logic [1:0] {
        ST_FILL      = 2'd0,
        ST_WAIT_NORM = 2'd1,
        ST_SCALE     = 2'd2
    } norm_scale_state_t;

endpackage

// File: rtl/scale_mul.sv
// Combinational Q8.8 scaler: signed element times unsigned reciprocal magnitude,
// round-half-up back to Q8.8, saturate to the signed W-bit range.
//   a_i        in  W  two's-complement Q8.8 element
//   inv_norm_i in  W  sign-magnitude Q8.8 reciprocal (sign bit ignored)
//   q_c        out W  scaled, rounded, saturated result
//   sat_c      out 1  result was clamped
module scale_mul
    import qr_pkg::*;
#(
    parameter int unsigned W = QW
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] inv_norm_i,
    output logic [W-1:0] q_c,
    output logic         sat_c
);

    localparam int unsigned PW = 2 * W;

    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] rnd_c;
    logic                 sat_hi_c;
    logic                 sat_lo_c;
    logic                 unused_c;

    // The reciprocal is non-negative by construction; its sign bit carries no information.
    assign unused_c = inv_norm_i[W-1];

    always_comb begin
        prod_c   = PW'($signed(a_i)) * PW'($signed({1'b0, inv_norm_i[W-2:0]}));
        rnd_c    = (prod_c + $signed(PW'(Q_ROUND))) >>> QF;
        // Result fits in W bits only if the bits above the W-bit sign all match it.
        sat_hi_c = ~rnd_c[PW-1] & (|rnd_c[PW-2:W-1]);
        sat_lo_c = rnd_c[PW-1] & ~(&rnd_c[PW-2:W-1]);
        sat_c    = sat_hi_c | sat_lo_c;
        if (sat_hi_c) begin
            q_c = W'(Q_MAX);
        end else if (sat_lo_c) begin
            q_c = W'(Q_MIN);
        end else begin
            q_c = rnd_c[W-1:0];
        end
    end

endmodule

// File: rtl/norm_scale.sv
// Buffers one column vector while its norm is computed, then streams
// q_k = a_k * inv_norm out through a registered valid/yumi output stage.
//   clk_i, reset_i          clock, synchronous active-high reset
//   a_i, v_i, ready_o       column element input handshake
//   inv_norm_i, inv_norm_v_i, overflow_i   reciprocal norm pulse from qdiv
//   q_o, v_o, yumi_i        scaled element output handshake
//   last_o                  q_o is the final element of the vector
//   sat_o                   sticky per vector: saturation or qdiv overflow
module norm_scale
    import qr_pkg::*;
#(
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned W       = QW
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [W-1:0] a_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic [W-1:0] inv_norm_i,
    input  logic         inv_norm_v_i,
    input  logic         overflow_i,
    output logic [W-1:0] q_o,
    output logic         v_o,
    input  logic         yumi_i,
    output logic         last_o,
    output logic         sat_o
);

    localparam int unsigned CNT_W = $clog2(VEC_LEN);
    localparam int unsigned IDX_W = $clog2(VEC_LEN + 1);

    norm_scale_state_t state_q;
    norm_scale_state_t state_d;

    logic [W-1:0]     elem_q [VEC_LEN];
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] idx_q;
    logic             norm_vld_q;
    logic             norm_ovf_q;
    logic [W-1:0]     norm_val_q;

    logic             accept_c;
    logic             load_c;
    logic             done_c;
    logic             enter_scale_c;
    logic [W-1:0]     rd_data_c;
    logic [W-1:0]     mul_q_c;
    logic             mul_sat_c;

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        state_d       = state_q;
        accept_c      = 1'b0;
        load_c        = 1'b0;
        done_c        = 1'b0;
        enter_scale_c = 1'b0;
        case (state_q)
            ST_FILL: begin
                accept_c = v_i & ready_o;
                if (accept_c && (count_q == CNT_W'(VEC_LEN - 1))) begin
                    // A norm that arrived early (or arrives now) skips the wait.
                    state_d = (norm_vld_q || inv_norm_v_i) ? ST_SCALE : ST_WAIT_NORM;
                end
            end
            ST_WAIT_NORM: begin
                if (norm_vld_q || inv_norm_v_i) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                // Refill the output register when it is empty or being drained this cycle.
                load_c = (idx_q < IDX_W'(VEC_LEN)) && (!v_o || yumi_i);
                done_c = v_o && yumi_i && last_o;
                if (done_c) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
        enter_scale_c = (state_q != ST_SCALE) && (state_d == ST_SCALE);
    end

    // Element buffer; stale contents are harmless because count/idx restart on reset.
    always_ff @(posedge clk_i) begin
        if (accept_c) begin
            elem_q[count_q] <= a_i;
        end
    end

    assign rd_data_c = elem_q[idx_q[CNT_W-1:0]];

    scale_mul #(
        .W (W)
    ) u_scale_mul (
        .a_i        (rd_data_c),
        .inv_norm_i (norm_val_q),
        .q_c        (mul_q_c),
        .sat_c      (mul_sat_c)
    );

    // Counters, norm latch and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q    <= '0;
            idx_q      <= '0;
            norm_vld_q <= 1'b0;
            norm_ovf_q <= 1'b0;
            norm_val_q <= '0;
            ready_o    <= 1'b1;
            q_o        <= '0;
            v_o        <= 1'b0;
            last_o     <= 1'b0;
            sat_o      <= 1'b0;
        end else begin
            ready_o <= (state_d == ST_FILL);

            if (accept_c) begin
                count_q <= count_q + CNT_W'(1);
            end

            if ((state_q != ST_SCALE) && inv_norm_v_i) begin
                norm_vld_q <= 1'b1;
                norm_val_q <= inv_norm_i;
                norm_ovf_q <= overflow_i;
            end

            if (done_c) begin
                count_q    <= '0;
                idx_q      <= '0;
                norm_vld_q <= 1'b0;
            end

            // sat_o stays visible after a vector until the next one starts scaling.
            if (enter_scale_c) begin
                sat_o <= 1'b0;
            end

            if (load_c) begin
                q_o    <= norm_ovf_q ? '0 : mul_q_c;
                v_o    <= 1'b1;
                last_o <= (idx_q == IDX_W'(VEC_LEN - 1));
                sat_o  <= sat_o | norm_ovf_q | mul_sat_c;
                idx_q  <= idx_q + IDX_W'(1);
            end else if (v_o && yumi_i) begin
                v_o    <= 1'b0;
                last_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_norm_scale.sv
// Randomized self-checking bench for norm_scale against an arithmetic reference model.
module tb_norm_scale;

    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned W       = 16;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [W-1:0] a_i;
    logic         v_i;
    logic         ready_o;
    logic [W-1:0] inv_norm_i;
    logic         inv_norm_v_i;
    logic         overflow_i;
    logic [W-1:0] q_o;
    logic         v_o;
    logic         yumi_i;
    logic         last_o;
    logic         sat_o;

    always #5 clk_i = ~clk_i;

    norm_scale #(
        .VEC_LEN (VEC_LEN),
        .W       (W)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .a_i          (a_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .inv_norm_i   (inv_norm_i),
        .inv_norm_v_i (inv_norm_v_i),
        .overflow_i   (overflow_i),
        .q_o          (q_o),
        .v_o          (v_o),
        .yumi_i       (yumi_i),
        .last_o       (last_o),
        .sat_o        (sat_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] cur_a [VEC_LEN];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Real-valued a * |inv| rounded half-up to 1/256, then clamped to the Q8.8 range.
    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] inv,
                                          output logic sat);
        longint p;
        longint r;
        p   = longint'($signed(a)) * longint'(inv & 16'h7FFF);
        r   = (p + 128) >>> 8;
        sat = 1'b0;
        if (r > 32767) begin
            sat = 1'b1;
            r   = 32767;
        end else if (r < -32768) begin
            sat = 1'b1;
            r   = -32768;
        end
        return 16'(r);
    endfunction

    task automatic pulse_norm(input logic [15:0] inv, input logic ovf);
        v_i          = 1'b0;
        inv_norm_i   = inv;
        overflow_i   = ovf;
        inv_norm_v_i = 1'b1;
        @(negedge clk_i);
        inv_norm_v_i = 1'b0;
        overflow_i   = 1'b0;
        inv_norm_i   = 16'($urandom);
    endtask

    // early_at: number of accepted elements before the norm pulse (VEC_LEN = after fill).
    // stall_k: element index at which yumi is held low 3 cycles (-1 none).
    // abort_after: stop consuming after this many handshakes (-1 run to completion).
    task automatic run_vec(input logic [15:0] inv, input logic ovf, input int early_at,
                           input int stall_k, input bit full_rate, input int abort_after,
                           input bit stray);
        logic [15:0] exp_q [VEC_LEN];
        logic        exp_s [VEC_LEN];
        logic        s;
        logic        s_run;
        int          k;
        int          cyc;
        int          first_cyc;
        int          stall_left;
        bit          stalled;

        s_run = 1'b0;
        for (int i = 0; i < int'(VEC_LEN); i++) begin
            exp_q[i] = ref_q(cur_a[i], inv, s);
            if (ovf) begin
                exp_q[i] = 16'h0000;
                s        = 1'b1;
            end
            s_run    = s_run | s;
            exp_s[i] = s_run;
        end

        if (early_at == 0) pulse_norm(inv, ovf);
        for (int i = 0; i < int'(VEC_LEN); i++) begin
            if ($urandom_range(2) == 0) begin
                v_i = 1'b0;
                @(negedge clk_i);
            end
            check_eq("fill_ready", 32'(ready_o), 32'd1);
            a_i = cur_a[i];
            v_i = 1'b1;
            @(negedge clk_i);
            if (early_at == i + 1) begin
                v_i = 1'b0;
                if (i + 1 == int'(VEC_LEN)) begin
                    repeat ($urandom_range(2)) begin
                        check_eq("wait_ready", 32'(ready_o), 32'd0);
                        check_eq("wait_v", 32'(v_o), 32'd0);
                        @(negedge clk_i);
                    end
                end
                pulse_norm(inv, ovf);
            end
        end
        v_i = 1'b0;

        k          = 0;
        cyc        = 0;
        first_cyc  = -1;
        stall_left = 0;
        stalled    = 1'b0;
        while (k < int'(VEC_LEN) && k != abort_after && cyc < 100) begin
            yumi_i = 1'b0;
            check_eq("scale_ready", 32'(ready_o), 32'd0);
            if (v_o) begin
                if (first_cyc < 0) first_cyc = cyc;
                check_eq("q", 32'(q_o), 32'(exp_q[k]));
                check_eq("last", 32'(last_o), 32'(k == int'(VEC_LEN) - 1));
                check_eq("sat", 32'(sat_o), 32'(exp_s[k]));
                if (k == stall_k && !stalled) begin
                    stall_left = 3;
                    stalled    = 1'b1;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else if (full_rate || $urandom_range(3) != 0) begin
                    yumi_i = 1'b1;
                    k++;
                end
            end else begin
                yumi_i = 1'($urandom_range(1));
            end
            if (stray) begin
                v_i          = 1'($urandom_range(1));
                a_i          = 16'($urandom);
                inv_norm_v_i = ($urandom_range(7) == 0);
                inv_norm_i   = 16'($urandom);
                overflow_i   = 1'($urandom_range(1));
            end
            @(negedge clk_i);
            cyc++;
        end
        yumi_i       = 1'b0;
        v_i          = 1'b0;
        inv_norm_v_i = 1'b0;
        overflow_i   = 1'b0;

        check_eq("handshakes", 32'(k), (abort_after < 0) ? 32'(VEC_LEN) : 32'(abort_after));
        check_eq("first_latency", 32'(first_cyc), 32'd1);
        if (full_rate && stall_k < 0 && abort_after < 0) begin
            check_eq("stream_cycles", 32'(cyc), 32'(VEC_LEN + 1));
        end
        if (abort_after < 0) begin
            check_eq("done_ready", 32'(ready_o), 32'd1);
            check_eq("done_v", 32'(v_o), 32'd0);
            check_eq("done_sat", 32'(sat_o), 32'(exp_s[VEC_LEN-1]));
        end
    endtask

    task automatic rand_vec();
        for (int i = 0; i < int'(VEC_LEN); i++) begin
            cur_a[i] = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(16'h0800));
        end
    endtask

    initial begin
        reset_i      = 1'b1;
        a_i          = '0;
        v_i          = 1'b0;
        inv_norm_i   = '0;
        inv_norm_v_i = 1'b0;
        overflow_i   = 1'b0;
        yumi_i       = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        check_eq("rst_ready", 32'(ready_o), 32'd1);
        check_eq("rst_v", 32'(v_o), 32'd0);
        check_eq("rst_q", 32'(q_o), 32'd0);
        check_eq("rst_last", 32'(last_o), 32'd0);
        check_eq("rst_sat", 32'(sat_o), 32'd0);

        cur_a = '{16'h0300, 16'h0400, 16'h0000, 16'h0000};
        run_vec(16'h0033, 1'b0, VEC_LEN, -1, 1'b1, -1, 1'b0);

        cur_a = '{16'hFD00, 16'h0100, 16'hFF00, 16'h0080};
        run_vec(16'h0033, 1'b0, VEC_LEN, -1, 1'b1, -1, 1'b0);

        cur_a = '{16'h7F00, 16'h8100, 16'h0100, 16'h0000};
        run_vec(16'h0200, 1'b0, VEC_LEN, -1, 1'b1, -1, 1'b0);

        rand_vec();
        run_vec(16'h0155, 1'b0, 2, 1, 1'b1, -1, 1'b1);

        rand_vec();
        run_vec(16'($urandom), 1'b1, VEC_LEN, -1, 1'b1, -1, 1'b0);

        cur_a = '{16'h0100, 16'hFF00, 16'h0280, 16'h0001};
        run_vec(16'h0100, 1'b0, VEC_LEN, -1, 1'b1, -1, 1'b0);

        rand_vec();
        run_vec(16'h0080, 1'b0, VEC_LEN, -1, 1'b1, 2, 1'b0);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        check_eq("midrst_v", 32'(v_o), 32'd0);
        check_eq("midrst_ready", 32'(ready_o), 32'd1);
        check_eq("midrst_last", 32'(last_o), 32'd0);
        check_eq("midrst_sat", 32'(sat_o), 32'd0);
        cur_a = '{16'h0200, 16'hFE00, 16'h0040, 16'h1000};
        run_vec(16'h00C0, 1'b0, VEC_LEN, -1, 1'b1, -1, 1'b0);

        repeat (25) begin
            rand_vec();
            run_vec(16'($urandom), ($urandom_range(5) == 0),
                    int'($urandom_range(VEC_LEN)),
                    int'($urandom_range(VEC_LEN)) - 1,
                    1'($urandom_range(1)), -1, 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
